// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its surroundings (ROM, Control, top level).
// master drives stimulus and observes; slave is the sequencer's view.
interface fetch_sequencer_if #(
    parameter int PC_W   = 10,
    parameter int INST_W = 9,
    parameter int CYC_W  = 16
);
    logic              Start;
    logic [INST_W-1:0] InstIn;
    logic              Halt;
    logic              Branch;
    logic              AccNonZero;
    logic              LutWe;
    logic [3:0]        LutAddr;
    logic [PC_W-1:0]   LutData;

    logic [PC_W-1:0]   InstAddr;
    logic              InstValid;
    logic              TypeBit;
    logic [3:0]        OP;
    logic [3:0]        RegSel;
    logic [7:0]        Imm;
    logic              Done;
    logic [CYC_W-1:0]  CycleCount;

    modport master (
        output Start, InstIn, Halt, Branch, AccNonZero, LutWe, LutAddr, LutData,
        input  InstAddr, InstValid, TypeBit, OP, RegSel, Imm, Done, CycleCount
    );

    modport slave (
        input  Start, InstIn, Halt, Branch, AccNonZero, LutWe, LutAddr, LutData,
        output InstAddr, InstValid, TypeBit, OP, RegSel, Imm, Done, CycleCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Front-end of the accumulator processor: owns the PC, slices the instruction,
// picks halt/branch/fall-through, and counts cycles spent running.
module fetch_sequencer #(
    parameter int PC_W   = 10,
    parameter int INST_W = 9,
    parameter int CYC_W  = 16
) (
    input logic               Clk,
    input logic               Reset,
    fetch_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [CYC_W-1:0] CYC_ONE = 1;

    logic [1:0]       state;
    logic [PC_W-1:0]  pc;
    logic [CYC_W-1:0] cyc;
    logic [PC_W-1:0]  lut [16];
    logic             type_bit;
    logic             taken;

    assign type_bit = bus.InstIn[INST_W-1];

    // Only bt (7) and bf (8) can be taken; any other opcode with Branch falls through.
    always_comb begin
        taken = 1'b0;
        if (bus.OP == 4'd7)
            taken = bus.AccNonZero;
        else if (bus.OP == 4'd8)
            taken = !bus.AccNonZero;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            pc    <= '0;
            cyc   <= '0;
            for (int unsigned i = 0; i < 16; i++)
                lut[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (bus.LutWe)
                        lut[bus.LutAddr] <= bus.LutData;
                    if (bus.Start) begin
                        state <= S_RUN;
                        pc    <= '0;
                        cyc   <= '0;
                    end
                end
                S_RUN: begin
                    if (cyc != '1)
                        cyc <= cyc + CYC_ONE;
                    if (type_bit && bus.Halt)
                        state <= S_HALTED;
                    else if (type_bit && bus.Branch && taken)
                        pc <= lut[bus.RegSel];
                    else
                        pc <= pc + PC_ONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.InstAddr   = pc;
    assign bus.InstValid  = (state == S_RUN);
    assign bus.Done       = (state == S_HALTED);
    assign bus.CycleCount = cyc;
    assign bus.TypeBit    = type_bit;
    assign bus.OP         = bus.InstIn[7:4];
    assign bus.RegSel     = bus.InstIn[3:0];
    assign bus.Imm        = bus.InstIn[7:0];
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end stage of the accumulator processor.
- Owns the program counter, drives the instruction ROM address, and splits the fetched 9-bit instruction into TypeBit/OP/operand fields for the Control decoder.
- Consumes Control's Halt and Branch outputs to pick the next PC: halt, branch through a 16-entry branch-target lookup table, or fall through.
- Runs a run/halt state machine with a Start/Done handshake to the testbench or top level, plus a cycle counter.

Parameters:
- PC_W, 10, width of program counter and instruction address.
- INST_W, 9, instruction width; bit 8 is TypeBit.
- CYC_W, 16, width of the saturating cycle counter.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse; launches program execution.
- InstIn  input  INST_W  instruction word from the ROM (asynchronous read of InstAddr).
- Halt  input  1  from Control; current instruction is halt.
- Branch  input  1  from Control; current instruction is bt/bf.
- AccNonZero  input  1  high when the accumulator is non-zero.
- LutWe  input  1  branch-table write enable.
- LutAddr  input  4  branch-table write index.
- LutData  input  PC_W  branch-table write data.
- InstAddr  output  PC_W  current PC; drives the ROM.
- InstValid  output  1  high only in RUN; downstream gates register, accumulator and memory writes with it.
- TypeBit  output  1  InstIn[8].
- OP  output  4  InstIn[7:4].
- RegSel  output  4  InstIn[3:0]; register index and branch key.
- Imm  output  8  InstIn[7:0]; immediate for geti.
- Done  output  1  high while in HALTED.
- CycleCount  output  CYC_W  cycles spent in RUN since the last launch.

Behaviour:
- States: IDLE, RUN, HALTED. Reset puts the block in IDLE.
- Reset values: PC=0, CycleCount=0, all 16 LUT entries=0, InstValid=0, Done=0.
- Field outputs (TypeBit, OP, RegSel, Imm) are combinational slices of InstIn in every state. InstAddr = PC.
- IDLE:
  - Start -> RUN; PC stays 0; CycleCount cleared.
  - LutWe writes lut[LutAddr]=LutData on the clock edge.
- RUN, evaluated on each rising edge in priority order:
  1. Halt -> HALTED; PC holds at the halt instruction.
  2. Branch with TypeBit=1 and taken -> PC = lut[RegSel].
     - Taken: OP=7 (bt) and AccNonZero=1, or OP=8 (bf) and AccNonZero=0.
     - Branch asserted with any other OP is treated as not taken.
  3. Otherwise -> PC = PC+1, wrapping modulo 2^PC_W (max value rolls to 0).
- CycleCount increments once per RUN cycle, including the halting cycle, and saturates at all-ones.
- Halt or Branch with TypeBit=0 is ignored: the instruction is an immediate and falls through to PC+1.
- HALTED:
  - Done=1; PC and CycleCount hold.
  - Start -> RUN with PC=0 and CycleCount=0 (restart).
  - LutWe is honoured.
- LutWe in RUN is ignored, so the table cannot change mid-program.
- A write and a branch lookup of the same entry in the same cycle cannot occur, since writes are blocked in RUN.
- Start in RUN is ignored.
- Start and Reset together: Reset wins; the block ends in IDLE.
- Reset mid-RUN aborts the program:
  - next cycle is IDLE with PC=0, InstValid=0, and the LUT cleared;
  - any LUT write issued in that cycle is dropped.
- Latency:
  - Next-PC decision is single-cycle; the instruction at the new PC is visible to Control in the following cycle.
  - Done rises the cycle after the halt instruction is presented.

Test Plan:
- Sequential run: load ROM 0..4 with geti, 5 with halt; Reset, pulse Start -> InstAddr steps 0,1,2,3,4,5. Done=1 the cycle after PC=5, PC holds at 5, CycleCount=6.
- bt taken vs not taken: lut[3]=40; instruction at PC=2 is bt key 3.
  - AccNonZero=1 -> PC=40 next cycle.
  - Repeat with AccNonZero=0 -> PC=3.
- bf mirror: lut[3]=40, bf key 3 at PC=2.
  - AccNonZero=0 -> PC=40.
  - AccNonZero=1 -> PC=3.
- LUT write protection: in RUN, pulse LutWe with LutAddr=5, LutData=99 while lut[5]=20 -> a later bt key 5 (taken) jumps to 20, not 99.
- Wrap and saturation:
  - Start with the ROM all geti -> PC goes 1023 -> 0; InstValid stays 1.
  - With CYC_W=4, CycleCount stops at 15.
- Reset mid-run then restart: Reset at PC=7 -> IDLE, PC=0, Done=0, lut[3] reads back 0. Start -> PC steps from 0. Start in HALTED restarts at PC=0 with CycleCount=0.
